// File: rtl/bank_arbiter.sv
// Two-requester arbiter in front of a 1W/1R 128x128 bank with independent
// round-robin write and read ports. Define BANK_ARB_FWD_EN to forward write
// data to a same-address read instead of stalling the read.
module bank_arbiter (
  input  logic         vsi_clk,
  input  logic         vsi_reset_n,
  input  logic [1:0]   req_valid,
  input  logic [1:0]   req_we,
  input  logic [13:0]  req_addr,
  input  logic [255:0] req_wdata,
  output logic [1:0]   req_ready,
  output logic [1:0]   rsp_valid,
  output logic [127:0] rsp_data,
  output logic         bank_inputChipSelect,
  output logic [6:0]   bank_inputAddr,
  output logic [127:0] bank_inputData,
  output logic         bank_outputChipSelect,
  output logic [6:0]   bank_outputAddr,
  input  logic [127:0] bank_outputData
);

  // Handshake: an operation transfers in a cycle where req_valid[r] && req_ready[r];
  // a requester that sees ready low may change or drop its request freely.

  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   wr_req;
  logic [1:0]   rd_req;
  logic         wr_any;
  logic         rd_any;
  logic         wr_sel;
  logic         rd_sel;
  logic [6:0]   wr_addr;
  logic [6:0]   rd_addr;
  logic [127:0] wr_data;
  logic         collide;
  logic         rd_go;
  logic         rd_port_en;
  logic [1:0]   wr_gnt;
  logic [1:0]   rd_gnt;

  always_comb begin
    wr_req = req_valid & req_we & {2{vsi_reset_n}};
    rd_req = req_valid & ~req_we & {2{vsi_reset_n}};
    wr_any = |wr_req;
    rd_any = |rd_req;
    wr_sel = (wr_req == 2'b11) ? wr_ptr : wr_req[1];
    rd_sel = (rd_req == 2'b11) ? rd_ptr : rd_req[1];
    wr_addr = wr_sel ? req_addr[13:7] : req_addr[6:0];
    rd_addr = rd_sel ? req_addr[13:7] : req_addr[6:0];
    wr_data = wr_sel ? req_wdata[255:128] : req_wdata[127:0];
    collide = wr_any && rd_any && (wr_addr == rd_addr);
`ifdef BANK_ARB_FWD_EN
    rd_go      = rd_any;
    rd_port_en = rd_any && !collide;
`else
    // The write wins a same-address collision; the read retries next cycle.
    rd_go      = rd_any && !collide;
    rd_port_en = rd_go;
`endif
    wr_gnt = {wr_any & wr_sel, wr_any & ~wr_sel};
    rd_gnt = {rd_go & rd_sel, rd_go & ~rd_sel};
  end

  assign req_ready             = wr_gnt | rd_gnt;
  assign bank_inputChipSelect  = wr_any;
  assign bank_inputAddr        = wr_addr;
  assign bank_inputData        = wr_data;
  assign bank_outputChipSelect = rd_port_en;
  assign bank_outputAddr       = rd_addr;

  // After any grant the pointer favours the requester that did not win.
  always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
    if (!vsi_reset_n) begin
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      rsp_valid <= 2'b00;
    end else begin
      if (wr_any) wr_ptr <= ~wr_sel;
      if (rd_go)  rd_ptr <= ~rd_sel;
      rsp_valid <= rd_gnt;
    end
  end

`ifdef BANK_ARB_FWD_EN
  logic         fwd_hit;
  logic [127:0] fwd_data;

  always_ff @(posedge vsi_clk or negedge vsi_reset_n) begin
    if (!vsi_reset_n) begin
      fwd_hit  <= 1'b0;
      fwd_data <= '0;
    end else begin
      fwd_hit <= collide;
      if (collide) fwd_data <= wr_data;
    end
  end

  assign rsp_data = fwd_hit ? fwd_data : bank_outputData;
`else
  assign rsp_data = bank_outputData;
`endif

endmodule

// File: tb/tb_bank_arbiter.sv
// Directed bench for bank_arbiter with a behavioural 1W/1R bank model;
// build with BANK_ARB_FWD_EN defined to exercise the forwarding variant.
module tb_bank_arbiter;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_we;
  logic [13:0]  req_addr;
  logic [255:0] req_wdata;
  logic [1:0]   req_ready;
  logic [1:0]   rsp_valid;
  logic [127:0] rsp_data;
  logic         in_cs;
  logic [6:0]   in_addr;
  logic [127:0] in_data;
  logic         out_cs;
  logic [6:0]   out_addr;
  logic [127:0] bank_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  bank_arbiter dut (
    .vsi_clk               (clk),
    .vsi_reset_n           (rst_n),
    .req_valid             (req_valid),
    .req_we                (req_we),
    .req_addr              (req_addr),
    .req_wdata             (req_wdata),
    .req_ready             (req_ready),
    .rsp_valid             (rsp_valid),
    .rsp_data              (rsp_data),
    .bank_inputChipSelect  (in_cs),
    .bank_inputAddr        (in_addr),
    .bank_inputData        (in_data),
    .bank_outputChipSelect (out_cs),
    .bank_outputAddr       (out_addr),
    .bank_outputData       (bank_rdata)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // bank model: unwritten words read back as 0x1000 + address
  bit [127:0] mem [128];
  bit         written [128];

  always @(posedge clk) begin
    if (in_cs) begin
      mem[in_addr]     <= in_data;
      written[in_addr] <= 1'b1;
    end
    if (out_cs)
      bank_rdata <= written[out_addr] ? mem[out_addr] : (128'h1000 + 128'(out_addr));
  end

  // driver tasks
  task automatic clear_reqs();
    req_valid = 2'b00;
    req_we    = 2'b00;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int r, input logic we, input logic [6:0] a,
                         input logic [127:0] d);
    req_valid[r]          = 1'b1;
    req_we[r]             = we;
    req_addr[r*7 +: 7]    = a;
    req_wdata[r*128 +: 128] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    clear_reqs();
    bank_rdata = '0;
    rst_n = 1'b0;
    #1;
    set_req(0, 1'b0, 7'd5, '0);
    #1;
    chk("rst_ready", 256'(req_ready), 256'(2'b00));
    chk("rst_in_cs", 256'(in_cs), 256'(1'b0));
    chk("rst_out_cs", 256'(out_cs), 256'(1'b0));
    chk("rst_rsp_valid", 256'(rsp_valid), 256'(2'b00));
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 256'(req_ready), 256'(2'b01));
    chk("rel_out_cs", 256'(out_cs), 256'(1'b1));
    chk("rel_out_addr", 256'(out_addr), 256'(7'd5));
    step();
    chk("rel_rsp_valid", 256'(rsp_valid), 256'(2'b01));
    chk("rel_rsp_data", 256'(rsp_data), 256'(128'h1005));

    // concurrent write (req0) and read (req1)
    clear_reqs();
    set_req(0, 1'b1, 7'd3, {16{8'hA5}});
    set_req(1, 1'b0, 7'd9, '0);
    #1;
    chk("wr_rd_ready", 256'(req_ready), 256'(2'b11));
    chk("wr_rd_in_cs", 256'(in_cs), 256'(1'b1));
    chk("wr_rd_in_addr", 256'(in_addr), 256'(7'd3));
    chk("wr_rd_in_data", 256'(in_data), 256'({16{8'hA5}}));
    chk("wr_rd_out_cs", 256'(out_cs), 256'(1'b1));
    chk("wr_rd_out_addr", 256'(out_addr), 256'(7'd9));
    step();
    chk("wr_rd_rsp_valid", 256'(rsp_valid), 256'(2'b10));
    chk("wr_rd_rsp_data", 256'(rsp_data), 256'(128'h1009));

    // write then read-back of the same word
    clear_reqs();
    set_req(0, 1'b1, 7'd7, 128'h1234);
    #1;
    chk("wr7_ready", 256'(req_ready), 256'(2'b01));
    step();
    chk("wr7_no_rsp", 256'(rsp_valid), 256'(2'b00));
    clear_reqs();
    set_req(0, 1'b0, 7'd7, '0);
    #1;
    chk("rd7_ready", 256'(req_ready), 256'(2'b01));
    chk("rd7_out_addr", 256'(out_addr), 256'(7'd7));
    step();
    chk("rd7_rsp_valid", 256'(rsp_valid), 256'(2'b01));
    chk("rd7_rsp_data", 256'(rsp_data), 256'(128'h1234));

    // read contention: pointer now favours req1
    clear_reqs();
    set_req(0, 1'b0, 7'd3, '0);
    set_req(1, 1'b0, 7'd9, '0);
    #1;
    chk("rdc_ready_a", 256'(req_ready), 256'(2'b10));
    step();
    chk("rdc_rsp_valid_a", 256'(rsp_valid), 256'(2'b10));
    chk("rdc_rsp_data_a", 256'(rsp_data), 256'(128'h1009));
    chk("rdc_ready_b", 256'(req_ready), 256'(2'b01));
    step();
    chk("rdc_rsp_valid_b", 256'(rsp_valid), 256'(2'b01));
    chk("rdc_rsp_data_b", 256'(rsp_data), 256'({16{8'hA5}}));

    // move both pointers to 1, then reset during a read accept
    clear_reqs();
    set_req(0, 1'b1, 7'd40, 128'h40);
    #1;
    chk("pre_wr_ready", 256'(req_ready), 256'(2'b01));
    step();
    clear_reqs();
    set_req(0, 1'b0, 7'd5, '0);
    #1;
    chk("pre_rd_ready", 256'(req_ready), 256'(2'b01));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 256'(req_ready), 256'(2'b00));
    chk("mid_rst_rsp_valid", 256'(rsp_valid), 256'(2'b00));
    step();
    chk("rst_no_pulse", 256'(rsp_valid), 256'(2'b00));
    step();
    rst_n = 1'b1;

    // both write continuously: grants alternate 0,1,0,1
    clear_reqs();
    set_req(0, 1'b1, 7'd50, 128'h50);
    set_req(1, 1'b1, 7'd51, 128'h51);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wr_alt_ready", 256'(req_ready), (i % 2 == 0) ? 256'(2'b01) : 256'(2'b10));
      chk("wr_alt_addr", 256'(in_addr), (i % 2 == 0) ? 256'(7'd50) : 256'(7'd51));
      step();
    end

    // read pointer is back to 0 after reset
    clear_reqs();
    set_req(0, 1'b0, 7'd50, '0);
    set_req(1, 1'b0, 7'd51, '0);
    #1;
    chk("rd_ptr_reset", 256'(req_ready), 256'(2'b01));
    step();
    chk("rd50_rsp_valid", 256'(rsp_valid), 256'(2'b01));
    chk("rd50_rsp_data", 256'(rsp_data), 256'(128'h50));

    // same-address collision: req0 writes 20, req1 reads 20
    clear_reqs();
    set_req(0, 1'b1, 7'd20, 128'hBEEF);
    set_req(1, 1'b0, 7'd20, '0);
    #1;
`ifdef BANK_ARB_FWD_EN
    chk("col_ready", 256'(req_ready), 256'(2'b11));
    chk("col_in_cs", 256'(in_cs), 256'(1'b1));
    chk("col_out_cs", 256'(out_cs), 256'(1'b0));
    step();
    chk("col_rsp_valid", 256'(rsp_valid), 256'(2'b10));
    chk("col_rsp_data", 256'(rsp_data), 256'(128'hBEEF));
    clear_reqs();
`else
    chk("col_ready", 256'(req_ready), 256'(2'b01));
    chk("col_in_cs", 256'(in_cs), 256'(1'b1));
    chk("col_out_cs", 256'(out_cs), 256'(1'b0));
    step();
    chk("col_no_rsp", 256'(rsp_valid), 256'(2'b00));
    clear_reqs();
    set_req(1, 1'b0, 7'd20, '0);
    #1;
    chk("col_retry_ready", 256'(req_ready), 256'(2'b10));
    chk("col_retry_out_cs", 256'(out_cs), 256'(1'b1));
    chk("col_retry_addr", 256'(out_addr), 256'(7'd20));
    step();
    chk("col_rsp_valid", 256'(rsp_valid), 256'(2'b10));
    chk("col_rsp_data", 256'(rsp_data), 256'(128'hBEEF));
    clear_reqs();
`endif
    step();
    chk("idle_rsp_valid", 256'(rsp_valid), 256'(2'b00));
    chk("idle_in_cs", 256'(in_cs), 256'(1'b0));
    chk("idle_out_cs", 256'(out_cs), 256'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bank_arbiter.md
BANK_ARBITER -- requirements
Module: bank_arbiter

Interface
REQ-001 SHALL have no parameters; widths fixed: ADDR 7 bits, DATA 128 bits, 2 requesters (index r = 0,1).
REQ-002 vsi_clk  in  1  sole clock, all state on rising edge.
REQ-003 vsi_reset_n  in  1  asynchronous active-low reset.
REQ-004 req_valid[r]  in  1  requester r presents one operation.
REQ-005 req_we[r]  in  1  1 = write, 0 = read.
REQ-006 req_addr[r]  in  7  word address, 0..127.
REQ-007 req_wdata[r]  in  128  write data, ignored on reads.
REQ-008 req_ready[r]  out  1  operation accepted this cycle (valid && ready = transfer).
REQ-009 rsp_valid[r]  out  1  read data for requester r valid this cycle.
REQ-010 rsp_data  out  128  read data, shared by both requesters, qualified by rsp_valid.
REQ-011 bank_inputChipSelect  out  1  bank write-port enable, active high.
REQ-012 bank_inputAddr  out  7  bank write address.
REQ-013 bank_inputData  out  128  bank write data.
REQ-014 bank_outputChipSelect  out  1  bank read-port enable, active high.
REQ-015 bank_outputAddr  out  7  bank read address.
REQ-016 bank_outputData  in  128  bank read data, valid the cycle after outputChipSelect.

Function
REQ-017 Write port and read port SHALL be arbitrated independently; one write and one read MAY be granted in the same cycle.
REQ-018 Each port SHALL have its own 1-bit round-robin pointer; when both requesters contend for a port, the pointed-to requester wins and the pointer then moves to the other requester.
REQ-019 An uncontended grant SHALL set that port's pointer to the non-granted requester.
REQ-020 req_ready, chip selects, addresses and write data SHALL be combinational from the current requests and pointers (zero-cycle accept).
REQ-021 A losing requester SHALL see req_ready=0 and SHALL be held until granted; the arbiter SHALL NOT require it to keep its inputs stable.
REQ-022 Read latency SHALL be exactly 1 cycle: rsp_valid[r]=1 in cycle N+1 for a read accepted in cycle N, with rsp_data = bank_outputData.
REQ-023 The granted-read requester index SHALL be registered so that rsp_valid routes to the correct requester; rsp_valid SHALL be 0 in cycles following no read grant.
REQ-024 Collision: if the granted write and granted read target the same address in one cycle, behaviour SHALL follow REQ-031/REQ-032.
REQ-025 Back-to-back reads on consecutive cycles SHALL each be accepted with full throughput (1 read/cycle, 1 write/cycle).
REQ-026 Chip selects SHALL be 0 in any cycle in which the corresponding port is not granted.

Reset
REQ-027 While vsi_reset_n=0: both pointers SHALL be 0 (requester 0 favoured), rsp_valid SHALL be 00, and the forward register SHALL be cleared.
REQ-028 While vsi_reset_n=0: req_ready, bank_inputChipSelect and bank_outputChipSelect SHALL be forced to 0.
REQ-029 A read accepted in the cycle in which reset asserts SHALL produce no rsp_valid.
REQ-030 The first rising edge after deassertion SHALL operate normally.

Configuration
REQ-031 With BANK_ARB_FWD_EN defined: on a same-address collision, both operations SHALL be granted, the bank read port SHALL NOT be enabled, and in cycle N+1 rsp_data SHALL be the colliding write data (registered), with rsp_valid as REQ-022.
REQ-032 Without BANK_ARB_FWD_EN: on a same-address collision, the write SHALL be granted and the read denied (req_ready=0); the read SHALL be re-arbitrated the following cycle and return the newly written data; the read pointer SHALL NOT change.

Verification
REQ-033 Reset asserted -> req_ready=00, both chip selects=0, rsp_valid=00; release with req0 read addr 5 -> rsp_valid[0]=1 one cycle later.
REQ-034 req0 write addr 3 data A5..A5 and req1 read addr 9, same cycle -> both ready, inputCS=1 addr 3, outputCS=1 addr 9, rsp_valid[1] next cycle.
REQ-035 Both requesters write continuously for 4 cycles after reset -> grants alternate 0,1,0,1.
REQ-036 Write addr 7 data 0x1234 then read addr 7 next cycle -> rsp_data=0x1234.
REQ-037 Same-cycle write addr 20 data 0xBEEF (req0) and read addr 20 (req1): FWD_EN -> both ready, outputCS=0, rsp_data=0xBEEF next cycle; no FWD_EN -> req1 ready=0, granted next cycle, rsp_data=0xBEEF one cycle after that.
REQ-038 Reset asserted one cycle after a read accept -> no rsp_valid pulse; pointers back to 0.
